// File: rtl/elem_rshift_seq_pkg.sv
// Shared types and sizing helpers for the chunked element right-shift sequencer.
package elem_rshift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_chunks(input int n, input int lanes);
    return (n + lanes - 1) / lanes;
  endfunction

  function automatic int cnt_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/elem_rshift_seq_if.sv
// Fixed-point context shared by the element-wise matrix ops: element width, clock and sync reset.
interface elem_rshift_seq_if #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic reset
);

  modport master (input clk, input reset);
  modport slave  (input clk, input reset);

endinterface

// File: rtl/elem_rshift_seq_shift.sv
// Combinational element-wise logical right shift of a ROWS x COLS matrix by a common amount.
module elem_rshift_seq_shift #(
  parameter int ROWS  = 1,
  parameter int COLS  = 1,
  parameter int WIDTH = 16
) (
  input  logic [ROWS:1][COLS:1][WIDTH-1:0] a,
  input  logic [4:0]                       b,
  output logic [ROWS:1][COLS:1][WIDTH-1:0] f
);

  // A shift amount at or beyond WIDTH already zero-fills the whole element.
  always_comb begin
    f = '0;
    for (int r = 1; r <= ROWS; r++) begin
      for (int c = 1; c <= COLS; c++) begin
        f[r][c] = a[r][c] >> b;
      end
    end
  end

endmodule

// File: rtl/elem_rshift_seq.sv
// Time-multiplexed matrix right shift: row-major chunks of LANES elements per clock through
// one shared shifter, behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; f holds the last result
// RUN   | chunk k of C being shifted and written into f
// DONE  | one-cycle done pulse; start here launches the next job
module elem_rshift_seq
  import elem_rshift_seq_pkg::*;
#(
  parameter int ROWS  = 1,
  parameter int COLS  = 1,
  parameter int LANES = 1,
  parameter int WIDTH = 16
) (
  elem_rshift_seq_if.slave                g,
  input  logic                            start,
  input  logic [ROWS:1][COLS:1][WIDTH-1:0] a,
  input  logic [4:0]                      b,
  output logic                            busy,
  output logic                            done,
  output logic [ROWS:1][COLS:1][WIDTH-1:0] f
);

  localparam int N  = ROWS * COLS;
  localparam int C  = num_chunks(N, LANES);
  localparam int KW = cnt_width(C);
  localparam int GW = g.WIDTH;

  state_e                    state_q, state_d;
  logic [KW-1:0]             k_q;
  logic [4:0]                b_q;
  logic [N-1:0][WIDTH-1:0]   opnd_q;
  logic [N-1:0][WIDTH-1:0]   res_q;
  logic [LANES-1:0][WIDTH-1:0] lane_in;
  logic [LANES-1:0][WIDTH-1:0] lane_out;
  logic                      capture;
  logic                      last;

  assign last = (k_q == KW'(C - 1));

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          capture = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        opnd_q <= a;
        b_q    <= b;
        k_q    <= '0;
      end else if (state_q == RUN && !last) begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  // Lanes past the end of the matrix in a partial last chunk are fed zero and never written back.
  always_comb begin
    lane_in = '0;
    for (int j = 0; j < C; j++) begin
      if (k_q == KW'(j)) begin
        for (int l = 0; l < LANES; l++) begin
          if (j * LANES + l < N) lane_in[l] = opnd_q[j * LANES + l];
        end
      end
    end
  end

  elem_rshift_seq_shift #(
    .ROWS  (1),
    .COLS  (LANES),
    .WIDTH (GW)
  ) u_shift (
    .a (lane_in),
    .b (b_q),
    .f (lane_out)
  );

  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      res_q <= '0;
    end else if (state_q == RUN) begin
      for (int j = 0; j < C; j++) begin
        for (int l = 0; l < LANES; l++) begin
          if (k_q == KW'(j) && j * LANES + l < N) res_q[j * LANES + l] <= lane_out[l];
        end
      end
    end
  end

  assign f    = res_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule
